// File: rtl/bitmap_dump.sv
// bitmap_dump: streams the 128x128 video RAM to the UART TX FIFO as ASCII.
//
// Scans the RAM in row-major order ({y, x} addressing, x in the low 7 bits)
// and writes each pixel as ASCII_BASE + pixel, so the host sees '0'..'7'.
// Two cycles per pixel: FETCH presents the address, SEND writes the byte
// once the synchronous RAM read data is valid. tx_full stalls SEND without
// losing or repeating a pixel.
//
// Optional build macro ROW_CRLF_EN: when defined, a CR (8'h0D) and an
// LF (8'h0A) byte follow the last pixel of every row, including the final
// row (16640 bytes total). When undefined, exactly 16384 bytes are sent.
module bitmap_dump #(
    parameter int          ADDR_WIDTH = 14,
    parameter int          DATA_WIDTH = 3,
    parameter logic [7:0]  ASCII_BASE = 8'h30
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    input  logic                  tx_full,
    output logic                  wr_tx,
    output logic [7:0]            w_data,
    output logic                  busy,
    output logic                  done_tick
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_SEND  = 3'd2;
`ifdef ROW_CRLF_EN
    localparam logic [2:0] S_CR    = 3'd3;
    localparam logic [2:0] S_LF    = 3'd4;
`endif
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  last_pixel;
    logic [7:0]            pixel_byte;

    assign last_pixel = &addr;
    assign pixel_byte = ASCII_BASE + {{(8-DATA_WIDTH){1'b0}}, ram_dout};

    // The read address is held at the current pixel through FETCH and SEND,
    // so the RAM keeps returning the same pixel for as long as SEND stalls.
    assign ram_addr  = addr;
    assign busy      = (state != S_IDLE);
    assign done_tick = (state == S_DONE);

`ifdef ROW_CRLF_EN
    logic row_end;
    assign row_end = (addr[6:0] == 7'h7f);
`endif

    // Scan sequencer: state transitions and pixel address counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            addr  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update in
            // this block based on the pre-edge values of state and addr.
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr  <= '0;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_SEND;
                S_SEND: begin
                    if (!tx_full) begin
`ifdef ROW_CRLF_EN
                        if (row_end) begin
                            state <= S_CR;
                        end else
`endif
                        if (last_pixel) begin
                            state <= S_DONE;
                        end else begin
                            addr  <= addr + ADDR_WIDTH'(1);
                            state <= S_FETCH;
                        end
                    end
                end
`ifdef ROW_CRLF_EN
                S_CR: begin
                    if (!tx_full) state <= S_LF;
                end
                S_LF: begin
                    if (!tx_full) begin
                        if (last_pixel) begin
                            state <= S_DONE;
                        end else begin
                            addr  <= addr + ADDR_WIDTH'(1);
                            state <= S_FETCH;
                        end
                    end
                end
`endif
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // FIFO write port: byte and strobe decoded from state, tx_full and RAM data.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves an output
        // unassigned, which would otherwise infer a latch.
        wr_tx  = 1'b0;
        w_data = 8'h00;
        case (state)
            S_SEND: begin
                w_data = pixel_byte;
                wr_tx  = !tx_full;
            end
`ifdef ROW_CRLF_EN
            S_CR: begin
                w_data = 8'h0D;
                wr_tx  = !tx_full;
            end
            S_LF: begin
                w_data = 8'h0A;
                wr_tx  = !tx_full;
            end
`endif
            default: begin
                wr_tx  = 1'b0;
                w_data = 8'h00;
            end
        endcase
    end

endmodule

// File: tb/tb_bitmap_dump.sv
// tb_bitmap_dump: directed self-checking bench for bitmap_dump.
// Cycle numbering: cycle 0 is the rising edge that samples start; outputs
// for cycle k are sampled 1 time unit after the k-th following falling edge.
module tb_bitmap_dump;

    localparam int AW = 14;
    localparam int DW = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          tx_full = 1'b0;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dout;
    logic          wr_tx;
    logic [7:0]    w_data;
    logic          busy;
    logic          done_tick;

    int ram_mode = 0;   // 0: pixel = addr[2:0], 1: constant 3'b010

    int n_pass  = 0;
    int n_total = 0;

    // Observations collected by run_dump
    logic [7:0]    wb[$];
    int            wc[$];
    int            done_cnt, done_cyc;
    logic          done_busy;
    int            stall_wr;
    logic [7:0]    st_d_first, st_d_last;
    logic [AW-1:0] st_a_first, st_a_last;
    int            timed_out;
    logic          rst_busy, rst_wr, rst_done;
    logic [7:0]    rst_wd;
    logic [AW-1:0] rst_addr;

    always #5 clk = ~clk;

    // Synchronous-read RAM model, one cycle of latency.
    always @(posedge clk) ram_dout <= (ram_mode == 0) ? ram_addr[2:0] : 3'b010;

    bitmap_dump dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .ram_addr  (ram_addr),
        .ram_dout  (ram_dout),
        .tx_full   (tx_full),
        .wr_tx     (wr_tx),
        .w_data    (w_data),
        .busy      (busy),
        .done_tick (done_tick)
    );

    // Bytes inserted by completed rows before pixel n.
    function automatic int crlf_extra(input int n);
`ifdef ROW_CRLF_EN
        return 2 * (n / 128);
`else
        return 0;
`endif
    endfunction

    function automatic int send_cyc(input int n);
        return 2 + 2 * n + crlf_extra(n);
    endfunction

    // Pulses start, then drives tx_full / extra start pulses / reset at the
    // given cycles and records every FIFO write. A cycle argument of -1
    // disables that stimulus.
    task automatic run_dump(input int stall_s, input int stall_len,
                            input int r1, input int r2,
                            input int reset_cyc, input int limit);
        int cyc;
        int post;
        bit st_first;
        wb.delete();
        wc.delete();
        done_cnt = 0; done_cyc = -1; done_busy = 1'b0;
        stall_wr = 0; st_first = 1'b1; timed_out = 0; post = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (cyc < limit) begin
            start   = (cyc == r1) || (cyc == r2);
            tx_full = (stall_s >= 0) && (cyc >= stall_s) && (cyc < stall_s + stall_len);
            if (cyc == reset_cyc) begin
                reset_n = 1'b0;
                #1;
                rst_busy = busy; rst_wr = wr_tx; rst_done = done_tick;
                rst_wd = w_data; rst_addr = ram_addr;
                start = 1'b0; tx_full = 1'b0;
                repeat (2) @(negedge clk);
                reset_n = 1'b1;
                break;
            end
            #1;
            if (wr_tx) begin
                wb.push_back(w_data);
                wc.push_back(cyc);
            end
            if (tx_full) begin
                if (wr_tx) stall_wr++;
                if (st_first) begin
                    st_d_first = w_data; st_a_first = ram_addr; st_first = 1'b0;
                end
                st_d_last = w_data; st_a_last = ram_addr;
            end
            if (done_tick) begin
                done_cnt++;
                done_cyc  = cyc;
                done_busy = busy;
            end
            if (done_cnt > 0 && !busy) begin
                post++;
                if (post >= 5) break;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        tx_full = 1'b0;
        if (cyc >= limit) timed_out = 1;
    endtask

    task automatic test_reset();
        int nwr;
        reset_n = 1'b0;
        start   = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++;
        if (wr_tx !== 1'b0) $display("FAIL reset_wr_tx: got %b want 0", wr_tx); else n_pass++;
        n_total++;
        if (ram_addr !== '0) $display("FAIL reset_ram_addr: got %0d want 0", ram_addr); else n_pass++;
        n_total++;
        if (w_data !== 8'h00 || done_tick !== 1'b0)
            $display("FAIL reset_data_done: w_data %h done %b want 00/0", w_data, done_tick);
        else n_pass++;
        @(negedge clk);
        start   = 1'b0;
        reset_n = 1'b1;
        nwr = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (wr_tx !== 1'b0 || busy !== 1'b0) nwr++;
        end
        n_total++;
        if (nwr != 0) $display("FAIL idle_quiet: %0d active cycles, want 0", nwr); else n_pass++;
    endtask

    // Pattern dump with a 10-cycle stall on pixel 5 and start pulses at
    // pixel 1000 and in the DONE cycle.
    task automatic test_pattern_backpressure_restart();
        logic [7:0] exp_b[$];
        int nbad, first_bad, stall_s, exp_done;
        ram_mode = 0;
        stall_s  = send_cyc(5);                 // 12
        exp_done = 32769 + 10 + crlf_extra(16384);
        run_dump(stall_s, 10, send_cyc(1000), exp_done, -1, 40000);
        for (int n = 0; n < 16384; n++) begin
            exp_b.push_back(8'h30 + 8'(n % 8));
`ifdef ROW_CRLF_EN
            if (n % 128 == 127) begin
                exp_b.push_back(8'h0D);
                exp_b.push_back(8'h0A);
            end
`endif
        end
        n_total++;
        if (timed_out != 0) $display("FAIL dump_timeout: no completion within budget"); else n_pass++;
        n_total++;
        if (wb.size() != exp_b.size())
            $display("FAIL dump_count: got %0d writes want %0d", wb.size(), exp_b.size());
        else n_pass++;
        nbad = 0; first_bad = -1;
        for (int i = 0; i < exp_b.size() && i < wb.size(); i++)
            if (wb[i] !== exp_b[i]) begin
                if (first_bad < 0) first_bad = i;
                nbad++;
            end
        n_total++;
        if (nbad != 0)
            $display("FAIL dump_bytes: %0d wrong, first at %0d got %h want %h",
                     nbad, first_bad, wb[first_bad], exp_b[first_bad]);
        else n_pass++;
        n_total++;
        if (wc.size() < 7 || wc[0] != 2 || wb[0] !== 8'h30)
            $display("FAIL first_write: cycle %0d byte %h want 2/30",
                     (wc.size() > 0) ? wc[0] : -1, (wb.size() > 0) ? wb[0] : 8'hxx);
        else n_pass++;
        n_total++;
        if (stall_wr != 0) $display("FAIL stall_no_write: %0d writes during stall want 0", stall_wr);
        else n_pass++;
        n_total++;
        if (st_d_first !== 8'h35 || st_d_last !== 8'h35)
            $display("FAIL stall_data_held: got %h..%h want 35", st_d_first, st_d_last);
        else n_pass++;
        n_total++;
        if (st_a_first !== AW'(5) || st_a_last !== AW'(5))
            $display("FAIL stall_addr_held: got %0d..%0d want 5", st_a_first, st_a_last);
        else n_pass++;
        n_total++;
        if (wc.size() < 7 || wc[5] != 22 || wc[6] != 24)
            $display("FAIL stall_release_timing: pixel5 at %0d pixel6 at %0d want 22/24",
                     (wc.size() > 6) ? wc[5] : -1, (wc.size() > 6) ? wc[6] : -1);
        else n_pass++;
        n_total++;
        if (done_cnt != 1) $display("FAIL done_single: got %0d done ticks want 1", done_cnt);
        else n_pass++;
        n_total++;
        if (done_cyc != exp_done) $display("FAIL done_cycle: got %0d want %0d", done_cyc, exp_done);
        else n_pass++;
        n_total++;
        if (done_busy !== 1'b1) $display("FAIL done_busy: got %b want 1", done_busy); else n_pass++;
    endtask

    task automatic test_reset_mid_dump();
        ram_mode = 0;
        run_dump(-1, 0, -1, -1, send_cyc(3000), 10000);
        n_total++;
        if (rst_busy !== 1'b0 || rst_wr !== 1'b0 || rst_done !== 1'b0)
            $display("FAIL abort_ctrl: busy %b wr_tx %b done %b want 0/0/0", rst_busy, rst_wr, rst_done);
        else n_pass++;
        n_total++;
        if (rst_addr !== '0 || rst_wd !== 8'h00)
            $display("FAIL abort_addr_data: addr %0d w_data %h want 0/00", rst_addr, rst_wd);
        else n_pass++;
        n_total++;
        if (wb.size() != 3000 + crlf_extra(3000))
            $display("FAIL abort_count: got %0d writes want %0d", wb.size(), 3000 + crlf_extra(3000));
        else n_pass++;
        // Fresh dump after the abort: restarts from pixel 0; cut short by reset.
        run_dump(-1, 0, -1, -1, 20, 100);
        n_total++;
        if (wb.size() != 9) $display("FAIL restart_count: got %0d writes want 9", wb.size());
        else n_pass++;
        n_total++;
        if (wb.size() < 9 || wc[0] != 2 || wb[0] !== 8'h30 || wb[1] !== 8'h31 || wb[8] !== 8'h30)
            $display("FAIL restart_from_zero: first byte %h at %0d want 30 at 2",
                     (wb.size() > 0) ? wb[0] : 8'hxx, (wc.size() > 0) ? wc[0] : -1);
        else n_pass++;
    endtask

`ifdef ROW_CRLF_EN
    task automatic test_crlf();
        int nbad, first_bad;
        logic [7:0] exp_b[$];
        ram_mode = 1;
        run_dump(-1, 0, -1, -1, -1, 40000);
        for (int r = 0; r < 128; r++) begin
            for (int x = 0; x < 128; x++) exp_b.push_back(8'h32);
            exp_b.push_back(8'h0D);
            exp_b.push_back(8'h0A);
        end
        n_total++;
        if (wb.size() != 16640) $display("FAIL crlf_count: got %0d want 16640", wb.size()); else n_pass++;
        nbad = 0; first_bad = -1;
        for (int i = 0; i < exp_b.size() && i < wb.size(); i++)
            if (wb[i] !== exp_b[i]) begin
                if (first_bad < 0) first_bad = i;
                nbad++;
            end
        n_total++;
        if (nbad != 0)
            $display("FAIL crlf_bytes: %0d wrong, first at %0d got %h want %h",
                     nbad, first_bad, wb[first_bad], exp_b[first_bad]);
        else n_pass++;
        n_total++;
        if (done_cyc != 33025) $display("FAIL crlf_done_cycle: got %0d want 33025", done_cyc); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_pattern_backpressure_restart();
        test_reset_mid_dump();
`ifdef ROW_CRLF_EN
        test_crlf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
